// File: rtl/slowsymf_pkg.sv
// Shared definitions for the slow symmetric FIR tap loader.
package slowsymf_pkg;

  localparam int unsigned LGNTAPS_DEF = 7;
  localparam int unsigned TW_DEF      = 12;
  localparam int unsigned NTAPS_DEF   = 107;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_LOAD
  } state_e;

  // Only the first half of a symmetric filter's coefficients is stored and loaded.
  function automatic int unsigned halftaps(input int unsigned ntaps);
    return ntaps >> 1;
  endfunction

endpackage

// File: rtl/slowsymf_coef_bank.sv
// Two coefficient banks in one simple dual-port RAM. The bank select is the address MSB.
module slowsymf_coef_bank #(
  parameter int unsigned LGNMEM = 6,
  parameter int unsigned TW     = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [LGNMEM:0]   i_waddr,
  input  logic [TW-1:0]     i_wdata,
  input  logic              i_rd,
  input  logic [LGNMEM:0]   i_raddr,
  output logic [TW-1:0]     o_rdata
);

  localparam int unsigned Depth = 2 << LGNMEM;

  logic [TW-1:0] mem_q [Depth];
  logic [TW-1:0] rdata_q;

  // Write port: the array contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Registered read port. Read latency is one cycle, and the output clears on reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdata_q <= '0;
    end else if (i_rd) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/slowsymf_tap_loader.sv
// Double-buffered coefficient loader for the slow symmetric FIR. On commit it resets the
// filter and streams HALFTAPS taps. It also gates the sample stream while a reload runs.
module slowsymf_tap_loader
  import slowsymf_pkg::*;
#(
  parameter int unsigned LGNTAPS = LGNTAPS_DEF,
  parameter int unsigned IW      = 16,
  parameter int unsigned TW      = TW_DEF,
  parameter int unsigned NTAPS   = NTAPS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [LGNTAPS-2:0]   i_waddr,
  input  logic [TW-1:0]        i_wdata,
  input  logic                 i_commit,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_ce,
  input  logic [IW-1:0]        i_sample,
  output logic                 o_ce,
  output logic [IW-1:0]        o_sample,
  output logic                 o_filter_reset,
  output logic                 o_tap_wr,
  output logic [TW-1:0]        o_tap,
  output logic [15:0]          o_dropped
);

  localparam int unsigned LGNMEM   = LGNTAPS - 1;
  localparam int unsigned HALFTAPS = halftaps(NTAPS);
  // HALFTAPS is at most (1<<LGNMEM)-1, so the index fits in LGNMEM bits.
  localparam logic [LGNMEM-1:0] LastIdx = LGNMEM'(HALFTAPS);

  state_e            state_q, state_d;
  logic [LGNMEM-1:0] ridx_q, ridx_d;
  logic              pending_q, pending_d;
  logic              active_q, active_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              frst_q;
  logic              tap_wr_q;
  logic              rd_en;
  logic              ce_q;
  logic [IW-1:0]     sample_q;
  logic [15:0]       dropped_q;

  // Next-state logic for the reload sequence. It includes one drain cycle in LOAD so the
  // last read can land.
  always_comb begin
    state_d   = state_q;
    ridx_d    = ridx_q;
    pending_d = pending_q;
    active_d  = active_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_commit || pending_q) begin
          active_d  = ~active_q;
          pending_d = 1'b0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        ridx_d  = '0;
        state_d = S_LOAD;
        if (i_commit) pending_d = 1'b1;
      end
      S_LOAD: begin
        if (i_commit) pending_d = 1'b1;
        if (ridx_q == LastIdx) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          rd_en  = 1'b1;
          ridx_d = ridx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control state and the registered reload outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      ridx_q    <= '0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frst_q    <= 1'b0;
      tap_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ridx_q    <= ridx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      frst_q    <= (state_d == S_RST);
      tap_wr_q  <= rd_en;
    end
  end

  // Sample gate and saturating drop counter. They use busy_d, so the commit cycle is gated too.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ce_q      <= 1'b0;
      sample_q  <= '0;
      dropped_q <= '0;
    end else begin
      ce_q     <= i_ce & ~busy_d;
      sample_q <= i_sample;
      if (i_ce && busy_d && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  slowsymf_coef_bank #(
    .LGNMEM (LGNMEM),
    .TW     (TW)
  ) u_bank (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (i_wr),
    .i_waddr ({~active_q, i_waddr}),
    .i_wdata (i_wdata),
    .i_rd    (rd_en),
    .i_raddr ({active_q, ridx_q}),
    .o_rdata (o_tap)
  );

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_filter_reset = frst_q;
  assign o_tap_wr       = tap_wr_q;
  assign o_ce           = ce_q;
  assign o_sample       = sample_q;
  assign o_dropped      = dropped_q;

endmodule

// File: tb/tb_slowsymf_tap_loader.sv
// Scoreboard bench for slowsymf_tap_loader. Expected taps and samples are queued at stimulus
// time and compared by the monitor when the DUT presents them.
module tb_slowsymf_tap_loader;

  localparam int LGNTAPS = 7;
  localparam int IW      = 16;
  localparam int TW      = 12;
  localparam int NTAPS   = 107;
  localparam int LGNMEM  = LGNTAPS - 1;
  localparam int HT      = NTAPS >> 1;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_wr = 1'b0;
  logic [LGNMEM-1:0] i_waddr = '0;
  logic [TW-1:0]     i_wdata = '0;
  logic              i_commit = 1'b0;
  logic              i_ce = 1'b0;
  logic [IW-1:0]     i_sample = '0;
  logic              o_busy, o_done, o_ce, o_filter_reset, o_tap_wr;
  logic [IW-1:0]     o_sample;
  logic [TW-1:0]     o_tap;
  logic [15:0]       o_dropped;

  slowsymf_tap_loader #(
    .LGNTAPS (LGNTAPS),
    .IW      (IW),
    .TW      (TW),
    .NTAPS   (NTAPS)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_waddr        (i_waddr),
    .i_wdata        (i_wdata),
    .i_commit       (i_commit),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .i_ce           (i_ce),
    .i_sample       (i_sample),
    .o_ce           (o_ce),
    .o_sample       (o_sample),
    .o_filter_reset (o_filter_reset),
    .o_tap_wr       (o_tap_wr),
    .o_tap          (o_tap),
    .o_dropped      (o_dropped)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shadow model of the two banks and the active-bank pointer.
  logic [TW-1:0] mdl [2][64];
  int            mdl_act = 0;

  logic [TW-1:0] tap_q [$];
  logic [IW-1:0] samp_q [$];
  bit            chk_en = 1'b1;
  int done_cnt = 0, frst_cnt = 0, tap_cnt = 0;
  int commit_cyc = 0, frst_cyc = 0, first_tap_cyc = 0, last_tap_cyc = 0, done_cyc = 0;
  bit in_stream = 1'b0;

  // Monitor: samples the outputs on the falling edge and pops the scoreboards.
  always @(negedge i_clk) begin
    if (i_commit) commit_cyc = cyc;
    if (o_filter_reset) begin
      frst_cnt++;
      frst_cyc  = cyc;
      in_stream = 1'b0;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_tap_wr) begin
      if (!in_stream) first_tap_cyc = cyc;
      in_stream    = 1'b1;
      last_tap_cyc = cyc;
      tap_cnt++;
      if (chk_en) begin
        check("tap_expected", tap_q.size() > 0, 1);
        if (tap_q.size() > 0) check("tap_value", o_tap, tap_q.pop_front());
      end
    end
    if (o_ce && chk_en) begin
      check("ce_no_overlap", o_tap_wr | o_filter_reset, 0);
      check("ce_expected", samp_q.size() > 0, 1);
      if (samp_q.size() > 0) check("sample_value", o_sample, samp_q.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    i_wr    = 1'b1;
    i_waddr = LGNMEM'(a);
    i_wdata = TW'(d);
    mdl[1 - mdl_act][a] = TW'(d);
    tick();
    i_wr = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int n = 0; n < HT; n++) wr(n, base + n);
  endtask

  // One-cycle commit. The bank that will be streamed is pushed onto the scoreboard here.
  task automatic commit_push();
    i_commit = 1'b1;
    mdl_act  = 1 - mdl_act;
    for (int n = 0; n < HT; n++) tap_q.push_back(mdl[mdl_act][n]);
    tick();
    i_commit = 1'b0;
  endtask

  task automatic samp(input logic [IW-1:0] v, input bit pass);
    i_ce     = 1'b1;
    i_sample = v;
    if (pass) samp_q.push_back(v);
    tick();
    i_ce = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, base, tbase;

    // Reset state
    tick(3);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_tap_wr", o_tap_wr, 0);
    check("rst_frst", o_filter_reset, 0);
    check("rst_ce", o_ce, 0);
    check("rst_dropped", o_dropped, 0);
    i_reset = 1'b0;
    tick(2);

    // Test 1: bank 1 gets coef n+1, then a commit at cycle t
    fill(1);
    commit_push();                      // now in t+1
    check("t1_frst_at_t1", o_filter_reset, 1);
    check("t1_busy_at_t1", o_busy, 1);
    tick();                             // t+2
    check("t1_frst_single", o_filter_reset, 0);
    check("t1_no_tap_at_t2", o_tap_wr, 0);
    wait_done(1);
    check("t1_frst_offset", frst_cyc - commit_cyc, 1);
    check("t1_first_tap_offset", first_tap_cyc - commit_cyc, 3);
    check("t1_last_tap_offset", last_tap_cyc - commit_cyc, 55);
    check("t1_done_offset", done_cyc - commit_cyc, 56);
    check("t1_tap_count", tap_cnt, 53);
    check("t1_queue_drained", tap_q.size(), 0);
    check("t1_idle_busy", o_busy, 0);

    // Test 2: sample gating around a reload; bank 0 gets 200+n
    fill(200);
    samp(16'h1111, 1'b1);
    check("t2_ce_latency", o_ce, 1);
    tick(118);
    i_ce = 1'b1;
    i_sample = 16'h2222;                // dropped: same cycle as the commit
    commit_push();                      // t+1
    i_ce = 1'b0;
    check("t2_ce_gated_commit", o_ce, 0);
    tick(18);                           // t+19
    samp(16'h3333, 1'b0);               // now t+20
    check("t2_dropped_2", o_dropped, 2);
    tick(34);                           // t+54, the last busy-gated input cycle
    samp(16'h4444, 1'b0);               // now t+55
    check("t2_ce_gated_t55", o_ce, 0);
    samp(16'h5555, 1'b1);               // input at t+55 passes; now t+56
    check("t2_ce_resume", o_ce, 1);
    check("t2_sample_resume", o_sample, 16'h5555);
    check("t2_done_t56", o_done, 1);
    check("t2_dropped_3", o_dropped, 3);
    tick(5);
    check("t2_samp_queue_drained", samp_q.size(), 0);

    // Test 3: a commit in LOAD cycle 10 queues one more reload from the other bank
    base = done_cnt;
    commit_push();                      // t+1, streams bank 1 (n+1)
    tick(11);                           // t+12 = LOAD cycle 10
    commit_push();                      // pending, streams bank 0 (200+n)
    wait_done(base + 1);
    d1 = done_cyc;
    wait_done(base + 2);
    check("t3_restart_next_cycle", frst_cyc - d1, 1);
    tick(80);
    check("t3_two_done", done_cnt - base, 2);
    check("t3_queue_drained", tap_q.size(), 0);

    // Test 4: write the shadow bank during LOAD
    commit_push();                      // streams bank 1 (n+1)
    tick(5);
    fill(500);                          // shadow is bank 0
    wait_done(base + 3);
    tick(5);
    commit_push();                      // streams bank 0 (500+n)
    wait_done(base + 4);
    tick(3);
    check("t4_queue_drained", tap_q.size(), 0);

    // Test 5: asynchronous reset in LOAD cycle 20
    commit_push();                      // t+1
    tick(21);                           // t+22
    check("t5_tap_wr_before", o_tap_wr, 1);
    check("t5_busy_before", o_busy, 1);
    i_reset = 1'b1;
    #1;
    check("t5_busy_abort", o_busy, 0);
    check("t5_tap_wr_abort", o_tap_wr, 0);
    check("t5_done_abort", o_done, 0);
    check("t5_dropped_clear", o_dropped, 0);
    tap_q.delete();
    mdl_act = 0;
    tick(2);
    i_reset = 1'b0;
    tick(2);
    tbase = tap_cnt;
    base  = done_cnt;
    commit_push();                      // bank 1 again (n+1)
    wait_done(base + 1);
    tick(2);
    check("t5_full_reload", tap_cnt - tbase, 53);
    check("t5_queue_drained", tap_q.size(), 0);

    // Test 6: hold commit and ce high so the drop counter runs past saturation
    chk_en   = 1'b0;
    i_ce     = 1'b1;
    i_commit = 1'b1;
    tick(70000);
    check("t6_dropped_sat", o_dropped, 16'hFFFF);
    tick(10);
    check("t6_dropped_hold", o_dropped, 16'hFFFF);
    i_ce     = 1'b0;
    i_commit = 1'b0;
    tick(200);
    check("t6_idle_after", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
